bsg_fpga_clk_gen: RTL and testbench
===================================

BSG_FPGA_CLK_GEN -- requirements
Module: bsg_fpga_clk_gen

Interface
REQ-001 Parameter div_width_p, default 8: width of each channel's divide value.
REQ-002 Parameter reset_div_p, default 0: divide value loaded into every channel at reset.
REQ-003 clk_i  input  1  single source clock; all state is on its rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 cfg_v_i  input  1  configuration request valid.
REQ-006 cfg_ch_i  input  2  target channel: 0=core, 1=io, 2=mc; 3 is reserved.
REQ-007 cfg_en_i  input  1  requested channel enable.
REQ-008 cfg_div_i  input  div_width_p  requested divide value d.
REQ-009 cfg_ready_o  output  1  the addressed channel can accept a request.
REQ-010 core_clk_o, io_clk_o, mc_clk_o  output  1 each  forwarded clocks to the ASIC, registered.
REQ-011 busy_o  output  3  per channel: an update is pending; bit 0 is core.

Function
REQ-012 Each channel SHALL be one of three states:
- STOP: output low, counter held at 0.
- RUN: counting.
- PEND: running, with a latched request not yet applied.
REQ-013 In RUN or PEND, each phase (high and low) SHALL last d+1 cycles, giving a period of 2*(d+1); d=0 gives clk_i/2.
REQ-014 The counter SHALL increment each cycle; at counter==d the output SHALL toggle and the counter SHALL clear.
REQ-015 A request SHALL be accepted only when cfg_v_i & cfg_ready_o.
REQ-016 cfg_ready_o SHALL be 0 if cfg_ch_i==3 or if the addressed channel is in PEND; reserved-channel requests are never accepted.
REQ-017 An accepted request to a RUN channel SHALL move it to PEND and latch en/div there.
REQ-018 A PEND request SHALL be applied only on the cycle the output falls (counter==d while high): that cycle the output goes low, div and en update, and the counter clears.
REQ-019 After a PEND request is applied, the channel SHALL enter RUN if en=1, or STOP if en=0.
REQ-020 An accepted request to a STOP channel SHALL apply on the next cycle; with en=1 the channel enters RUN with its output low and first rises d+1 cycles later.
REQ-021 No output SHALL produce a high or low pulse shorter than min(old d, new d)+1 cycles.
REQ-022 busy_o[c] SHALL be 1 exactly while channel c is in PEND.
REQ-023 Channels SHALL operate independently; only the addressed channel sees a request.

Reset
REQ-024 On reset_n_i low, all channels SHALL enter STOP asynchronously, with div=reset_div_p, counter 0, all clock outputs 0, busy_o=0 and cfg_ready_o combinational from the reset state.
REQ-025 Asserting reset during PEND SHALL discard the pending request.

Configuration
REQ-026 With BSG_FPGA_CLK_GEN_MONITOR_EN defined, the module SHALL add output edge_cnt_o (3x16 bits):
- per-channel free-running count of output rising edges;
- wraps 0xFFFF->0;
- cleared by reset only.
REQ-027 Without BSG_FPGA_CLK_GEN_MONITOR_EN, edge_cnt_o and its counters SHALL be absent.

Structure
REQ-028 Package bsg_fpga_clk_gen_pkg SHALL hold:
- the channel index enum (core, io, mc);
- the channel count constant 3;
- the channel state enum (STOP, RUN, PEND).
REQ-029 The per-channel counter and state machine SHALL be sub-module bsg_fpga_clk_gen_ch, instantiated three times; the top holds only decode and ready muxing.

Verification
REQ-030 Reset, then request ch0 en=1 d=0 -> core_clk_o toggles every cycle, period 2; io and mc stay 0.
REQ-031 ch1 running d=3, then request d=1 mid high phase:
- the current high phase completes 4 cycles;
- busy_o[1]=1 until the fall;
- the following phases are 2 cycles.
REQ-032 ch2 in PEND, second request to ch2 -> cfg_ready_o=0 and the request is not accepted; a simultaneous-cycle request to ch0 is accepted.
REQ-033 ch0 running d=2, request en=0 -> the output completes its high phase, falls, then stays 0; state STOP.
REQ-034 Assert reset_n_i during ch1 PEND -> all outputs 0 immediately; after release the channel is in STOP and the old request is not applied.
REQ-035 cfg_ch_i=3 with cfg_v_i=1 -> cfg_ready_o=0 and no channel changes.

Source files
------------

// File: rtl/bsg_fpga_clk_gen_pkg.sv
// bsg_fpga_clk_gen_pkg: shared channel indices, channel count and channel states
package bsg_fpga_clk_gen_pkg;
  typedef enum logic [1:0] {CH_CORE, CH_IO, CH_MC} ch_e;
  localparam int num_ch_lp = 3;
  typedef enum logic [1:0] {STOP, RUN, PEND} ch_state_e;
endpackage

// File: rtl/bsg_fpga_clk_gen_ch.sv
// bsg_fpga_clk_gen_ch: one divided clock channel; edge_cnt_o only with BSG_FPGA_CLK_GEN_MONITOR_EN
module bsg_fpga_clk_gen_ch
  import bsg_fpga_clk_gen_pkg::*;
#(
  parameter int div_width_p = 8,
  parameter int reset_div_p = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   req_i,
  input  logic                   en_i,
  input  logic [div_width_p-1:0] div_i,
  output logic                   clk_o,
  output logic                   busy_o
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
  ,
  output logic [15:0]            edge_cnt_o
`endif
);
  ch_state_e              state_r;
  logic [div_width_p-1:0] div_r, cnt_r, pend_div_r;
  logic                   pend_en_r, wrap;
  assign wrap = cnt_r == div_r;
  // Channel FSM: updates wait for a falling edge so no phase is ever cut short
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r    <= STOP;
      div_r      <= div_width_p'(reset_div_p);
      cnt_r      <= '0;
      clk_o      <= 1'b0;
      busy_o     <= 1'b0;
      pend_en_r  <= 1'b0;
      pend_div_r <= '0;
    end else
      case (state_r)
        STOP:
          if (req_i) begin
            state_r <= en_i ? RUN : STOP;
            div_r   <= div_i;
          end
        RUN: begin
          cnt_r <= wrap ? '0 : cnt_r + div_width_p'(1);
          clk_o <= clk_o ^ wrap;
          if (req_i) begin
            state_r    <= PEND;
            busy_o     <= 1'b1;
            pend_en_r  <= en_i;
            pend_div_r <= div_i;
          end
        end
        default: begin
          cnt_r <= wrap ? '0 : cnt_r + div_width_p'(1);
          clk_o <= clk_o ^ wrap;
          if (wrap && clk_o) begin
            state_r <= pend_en_r ? RUN : STOP;
            busy_o  <= 1'b0;
            div_r   <= pend_div_r;
          end
        end
      endcase
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
  // Count output rising edges, wrapping freely
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) edge_cnt_o <= '0;
    else if (state_r != STOP && wrap && !clk_o) edge_cnt_o <= edge_cnt_o + 16'd1;
`endif
endmodule

// File: rtl/bsg_fpga_clk_gen.sv
// bsg_fpga_clk_gen: three-channel FPGA clock divider; BSG_FPGA_CLK_GEN_MONITOR_EN adds edge_cnt_o
module bsg_fpga_clk_gen
  import bsg_fpga_clk_gen_pkg::*;
#(
  parameter int div_width_p = 8,
  parameter int reset_div_p = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   cfg_v_i,
  input  logic [1:0]             cfg_ch_i,
  input  logic                   cfg_en_i,
  input  logic [div_width_p-1:0] cfg_div_i,
  output logic                   cfg_ready_o,
  output logic                   core_clk_o,
  output logic                   io_clk_o,
  output logic                   mc_clk_o,
  output logic [2:0]             busy_o
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
  ,
  output logic [47:0]            edge_cnt_o
`endif
);
  logic [num_ch_lp-1:0] clk_w;
  logic [num_ch_lp:0]   blocked;
  assign blocked     = {1'b1, busy_o};
  assign cfg_ready_o = ~blocked[cfg_ch_i];
  assign core_clk_o  = clk_w[CH_CORE];
  assign io_clk_o    = clk_w[CH_IO];
  assign mc_clk_o    = clk_w[CH_MC];
  genvar c;
  for (c = 0; c < num_ch_lp; c++) begin : ch
    bsg_fpga_clk_gen_ch #(
      .div_width_p(div_width_p),
      .reset_div_p(reset_div_p)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .req_i     (cfg_v_i & cfg_ready_o & (cfg_ch_i == 2'(c))),
      .en_i      (cfg_en_i),
      .div_i     (cfg_div_i),
      .clk_o     (clk_w[c]),
      .busy_o    (busy_o[c])
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
      ,
      .edge_cnt_o(edge_cnt_o[16*c+:16])
`endif
    );
  end
endmodule

// File: tb/tb_bsg_fpga_clk_gen.sv
// tb_bsg_fpga_clk_gen: directed self-checking bench for bsg_fpga_clk_gen
module tb_bsg_fpga_clk_gen;
  logic       clk_i = 1'b0, reset_n_i = 1'b1, cfg_v_i = 1'b0, cfg_en_i = 1'b0;
  logic [1:0] cfg_ch_i = 2'd0;
  logic [7:0] cfg_div_i = 8'd0;
  logic       cfg_ready_o, core_clk_o, io_clk_o, mc_clk_o;
  logic [2:0] busy_o;
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
  logic [47:0] edge_cnt_o;
`endif
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_fpga_clk_gen dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .cfg_v_i    (cfg_v_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_en_i   (cfg_en_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_ready_o(cfg_ready_o),
    .core_clk_o (core_clk_o),
    .io_clk_o   (io_clk_o),
    .mc_clk_o   (mc_clk_o),
    .busy_o     (busy_o)
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
    ,
    .edge_cnt_o (edge_cnt_o)
`endif
  );

  // called at a negedge; the request is presented for exactly one rising edge
  task automatic send(input logic [1:0] ch, input logic en, input logic [7:0] d);
    cfg_v_i = 1'b1; cfg_ch_i = ch; cfg_en_i = en; cfg_div_i = d;
    @(negedge clk_i);
    cfg_v_i = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset_n_i = 1'b0;
    #1;
    checks++; if ({core_clk_o, io_clk_o, mc_clk_o} !== 3'b000) begin errors++; $display("FAIL reset_clks got %b want 000", {core_clk_o, io_clk_o, mc_clk_o}); end
    checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", busy_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_ch0 got %b want 1", cfg_ready_o); end
    cfg_ch_i = 2'd3; #1;
    checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_ch3 got %b want 0", cfg_ready_o); end
`ifdef BSG_FPGA_CLK_GEN_MONITOR_EN
    checks++; if (edge_cnt_o !== 48'd0) begin errors++; $display("FAIL reset_edge_cnt got %h want 0", edge_cnt_o); end
`endif
    cfg_ch_i = 2'd0;
    @(negedge clk_i); @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_div0;
    logic [3:0] exp;
    exp = 4'b1010;
    send(2'd0, 1'b1, 8'd0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (core_clk_o !== exp[k]) begin errors++; $display("FAIL div0_core[%0d] got %b want %b", k, core_clk_o, exp[k]); end
      checks++; if ({io_clk_o, mc_clk_o} !== 2'b00) begin errors++; $display("FAIL div0_io_mc[%0d] got %b want 00", k, {io_clk_o, mc_clk_o}); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_pend_change;
    logic [15:0] exp_io, exp_b;
    exp_io = 16'b1100_1100_1111_0000;
    exp_b  = 16'b0000_0000_1100_0000;
    send(2'd1, 1'b1, 8'd3);
    for (int k = 0; k < 16; k++) begin
      checks++; if (io_clk_o !== exp_io[k]) begin errors++; $display("FAIL pend_io[%0d] got %b want %b", k, io_clk_o, exp_io[k]); end
      checks++; if (busy_o[1] !== exp_b[k]) begin errors++; $display("FAIL pend_busy1[%0d] got %b want %b", k, busy_o[1], exp_b[k]); end
      if (k == 5) begin cfg_v_i = 1'b1; cfg_ch_i = 2'd1; cfg_en_i = 1'b1; cfg_div_i = 8'd1; end
      if (k == 6) cfg_v_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  task automatic test_ready_conflict;
    int   n;
    logic prev;
    send(2'd2, 1'b1, 8'd3);
    send(2'd2, 1'b1, 8'd1);
    cfg_v_i = 1'b1; cfg_ch_i = 2'd2; cfg_en_i = 1'b0; cfg_div_i = 8'd0; #1;
    checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL conflict_ready_ch2 got %b want 0", cfg_ready_o); end
    checks++; if (busy_o[2] !== 1'b1) begin errors++; $display("FAIL conflict_busy2 got %b want 1", busy_o[2]); end
    @(negedge clk_i);
    checks++; if (busy_o[2] !== 1'b1) begin errors++; $display("FAIL conflict_busy2_hold got %b want 1", busy_o[2]); end
    cfg_ch_i = 2'd0; cfg_en_i = 1'b1; cfg_div_i = 8'd2; #1;
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL conflict_ready_ch0 got %b want 1", cfg_ready_o); end
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL conflict_busy0 got %b want 1", busy_o[0]); end
    repeat (20) @(negedge clk_i);
    checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL conflict_busy_clear got %b want 000", busy_o); end
    n = 0; prev = mc_clk_o;
    repeat (8) begin @(negedge clk_i); if (mc_clk_o !== prev) n++; prev = mc_clk_o; end
    checks++; if (n != 4) begin errors++; $display("FAIL conflict_mc_toggles got %0d want 4", n); end
  endtask

  task automatic test_stop;
    logic prev, found;
    found = 1'b0; prev = core_clk_o;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk_i);
      if (core_clk_o === 1'b1 && prev === 1'b0) found = 1'b1;
      prev = core_clk_o;
    end
    checks++; if (!found) begin errors++; $display("FAIL stop_rise_timeout got none want rise"); end
    cfg_v_i = 1'b1; cfg_ch_i = 2'd0; cfg_en_i = 1'b0; cfg_div_i = 8'd0;
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    checks++; if (core_clk_o !== 1'b1) begin errors++; $display("FAIL stop_high2 got %b want 1", core_clk_o); end
    checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL stop_busy0 got %b want 1", busy_o[0]); end
    @(negedge clk_i);
    checks++; if (core_clk_o !== 1'b1) begin errors++; $display("FAIL stop_high3 got %b want 1", core_clk_o); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checks++; if (core_clk_o !== 1'b0) begin errors++; $display("FAIL stop_low[%0d] got %b want 0", i, core_clk_o); end
    end
    checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL stop_busy0_clear got %b want 0", busy_o[0]); end
  endtask

  task automatic test_reserved;
    int   n_io, n_mc;
    logic p_io, p_mc;
    cfg_v_i = 1'b1; cfg_ch_i = 2'd3; cfg_en_i = 1'b0; cfg_div_i = 8'd0; #1;
    checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reserved_ready got %b want 0", cfg_ready_o); end
    n_io = 0; n_mc = 0; p_io = io_clk_o; p_mc = mc_clk_o;
    repeat (8) begin
      @(negedge clk_i);
      if (io_clk_o !== p_io) n_io++;
      if (mc_clk_o !== p_mc) n_mc++;
      p_io = io_clk_o; p_mc = mc_clk_o;
    end
    cfg_v_i = 1'b0;
    checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL reserved_busy got %b want 000", busy_o); end
    checks++; if (n_io != 4) begin errors++; $display("FAIL reserved_io_toggles got %0d want 4", n_io); end
    checks++; if (n_mc != 4) begin errors++; $display("FAIL reserved_mc_toggles got %0d want 4", n_mc); end
  endtask

  task automatic test_reset_pend;
    send(2'd1, 1'b1, 8'd5);
    for (int i = 0; i < 8 && io_clk_o !== 1'b1; i++) @(negedge clk_i);
    checks++; if (io_clk_o !== 1'b1) begin errors++; $display("FAIL rstpend_high_timeout got %b want 1", io_clk_o); end
    checks++; if (busy_o[1] !== 1'b1) begin errors++; $display("FAIL rstpend_busy1 got %b want 1", busy_o[1]); end
    #2 reset_n_i = 1'b0;
    #1;
    checks++; if ({core_clk_o, io_clk_o, mc_clk_o} !== 3'b000) begin errors++; $display("FAIL rstpend_clks got %b want 000", {core_clk_o, io_clk_o, mc_clk_o}); end
    checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL rstpend_busy got %b want 000", busy_o); end
    @(negedge clk_i); @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      checks++; if ({io_clk_o, mc_clk_o} !== 2'b00) begin errors++; $display("FAIL rstpend_stop[%0d] got %b want 00", i, {io_clk_o, mc_clk_o}); end
    end
    checks++; if (busy_o !== 3'b000) begin errors++; $display("FAIL rstpend_busy_after got %b want 000", busy_o); end
    cfg_ch_i = 2'd1; #1;
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rstpend_ready1 got %b want 1", cfg_ready_o); end
  endtask

  initial begin
    test_reset;
    test_div0;
    test_pend_change;
    test_ready_conflict;
    test_stop;
    test_reserved;
    test_reset_pend;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
